// File: rtl/decryption_pkg.sv
// rtl/decryption_pkg.sv - shared constants for the decryption register bank and its master
package decryption_pkg;

  // Default widths of the register bank
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_REG_WIDTH  = 16;
  localparam int DEF_TIMEOUT    = 16;

  // Bank register map
  localparam logic [7:0] SELECT_ADDR      = 8'h00;
  localparam logic [7:0] CAESAR_KEY_ADDR  = 8'h10;
  localparam logic [7:0] SCYTALE_KEY_ADDR = 8'h12;
  localparam logic [7:0] ZIGZAG_KEY_ADDR  = 8'h14;

  // Master FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

endpackage

// File: rtl/decryption_regfile_master_if.sv
// rtl/decryption_regfile_master_if.sv - command, response and bank signals of the register master
interface decryption_regfile_master_if
  import decryption_pkg::*;
#(
  parameter int addr_width = DEF_ADDR_WIDTH,
  parameter int reg_width  = DEF_REG_WIDTH
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [addr_width-1:0] cmd_addr;
  logic [reg_width-1:0]  cmd_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [reg_width-1:0]  rsp_rdata;
  logic                  rsp_error;
  logic                  rsp_timeout;

  logic [addr_width-1:0] addr;
  logic                  read;
  logic                  write;
  logic [reg_width-1:0]  wdata;
  logic [reg_width-1:0]  rdata;
  logic                  done;
  logic                  error;

  // The register master's own view
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
    input  rsp_ready,
    output addr, read, write, wdata,
    input  rdata, done, error
  );

  // Surroundings: configuration source plus register bank
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
    output rsp_ready,
    input  addr, read, write, wdata,
    output rdata, done, error
  );

endinterface

// File: rtl/decryption_timeout_cnt.sv
// rtl/decryption_timeout_cnt.sv - saturating WAIT-cycle counter with expiry flag
module decryption_timeout_cnt #(
  parameter int limit = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int cw = $clog2(limit + 1);
  localparam logic [cw-1:0] last = cw'(limit - 1);
  localparam logic [cw-1:0] top  = cw'(limit);

  logic [cw-1:0] cnt;

  // Count idle WAIT cycles, holding at the limit instead of wrapping
  always_ff @(posedge clk) begin
    if (rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != top)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Expires in the cycle whose increment would reach the limit
  assign expired = enable && (cnt >= last);

endmodule

// File: rtl/decryption_regfile_master.sv
// rtl/decryption_regfile_master.sv - single-outstanding register access initiator for the decryption bank
module decryption_regfile_master
  import decryption_pkg::*;
#(
  parameter int addr_width     = DEF_ADDR_WIDTH,
  parameter int reg_width      = DEF_REG_WIDTH,
  parameter int timeout_cycles = DEF_TIMEOUT
) (
  input logic                           clk,
  input logic                           rst_n,
  decryption_regfile_master_if.master   bus
);

  logic [1:0]            state;
  logic                  wr_q;
  logic [addr_width-1:0] addr_q;
  logic [reg_width-1:0]  wdata_q;
  logic [reg_width-1:0]  rsp_rdata_q;
  logic                  rsp_error_q;
  logic                  rsp_timeout_q;
  logic                  expired;

  decryption_timeout_cnt #(.limit(timeout_cycles)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state == ST_ISSUE),
    .enable  ((state == ST_WAIT) && !bus.done),
    .expired (expired)
  );

  // Command latch, access sequencing and response capture
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state         <= ST_IDLE;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rsp_rdata_q   <= '0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            wr_q    <= bus.cmd_write;
            addr_q  <= bus.cmd_addr;
            wdata_q <= bus.cmd_wdata;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (bus.done) begin
            rsp_error_q   <= bus.error;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= (!wr_q && !bus.error) ? bus.rdata : '0;
            state         <= ST_RESP;
          end else if (expired) begin
            rsp_error_q   <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_rdata_q   <= '0;
            state         <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Strobes exist only in ISSUE; cmd_ready is held low while reset is applied
  assign bus.cmd_ready   = (state == ST_IDLE) && !rst_n;
  assign bus.read        = (state == ST_ISSUE) && !wr_q;
  assign bus.write       = (state == ST_ISSUE) && wr_q;
  assign bus.addr        = addr_q;
  assign bus.wdata       = wdata_q;
  assign bus.rsp_valid   = (state == ST_RESP);
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_error   = rsp_error_q;
  assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: doc/decryption_regfile_master.md
# decryption_regfile_master

Register-access initiator for the decryption register bank. It accepts single read or write commands from the configuration side over a valid/ready handshake, drives the bank's addr/read/write/wdata strobes, and waits for done. It captures rdata and error (or flags a timeout) and returns one response per command over a second valid/ready handshake. It sits between the top-level configuration source and the register bank that holds select and the three cipher keys.

## Interface
- addr_width, 8, register address width; matches the bank.
- reg_width, 16, register data width; matches the bank.
- timeout_cycles, 16, number of WAIT cycles without done before the access is abandoned; legal range 1..255.

- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  reset; synchronous, active-high despite the name: rst_n=1 on a rising edge resets the block.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  addr_width  target register address.
- cmd_wdata  in  reg_width  write data; ignored for reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  reg_width  read data; 0 for writes, errors and timeouts.
- rsp_error  out  1  bank reported error, or timeout.
- rsp_timeout  out  1  no done within timeout_cycles.
- addr  out  addr_width  to bank.
- read  out  1  to bank; one-cycle strobe.
- write  out  1  to bank; one-cycle strobe.
- wdata  out  reg_width  to bank.
- rdata  in  reg_width  from bank.
- done  in  1  from bank.
- error  in  1  from bank.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch cmd_write, cmd_addr and cmd_wdata, then go to ISSUE.
- ISSUE:
  - Drive addr and wdata from the latched values.
  - Assert exactly one of read/write for this single cycle.
  - Clear the timeout counter, then go to WAIT.
- WAIT:
  - addr and wdata stay held; read=write=0.
  - When done=1: capture error. If the access was a read and error=0, also capture rdata; otherwise rsp_rdata=0. Go to RESP.
  - When done=0: increment the counter. When the counter reaches timeout_cycles, set rsp_timeout=1, rsp_error=1, rsp_rdata=0 and go to RESP.
- RESP:
  - rsp_valid=1 and rsp_* stay stable until rsp_ready=1. On that edge, return to IDLE.
  - No bypass: cmd_ready=0 in the RESP cycle.
- The bank's error is taken as-is: an invalid address gives rsp_error=1 and rsp_timeout=0.
- done, error and rdata are ignored outside WAIT. A stray done in IDLE, ISSUE or RESP has no effect.
- read and write are never high together, and never high outside ISSUE.
- The counter is wide enough for timeout_cycles and saturates; it never wraps.

## Timing
- Reset values:
  - State IDLE.
  - addr, wdata, read, write, rsp_rdata, rsp_error, rsp_timeout and rsp_valid are all 0.
  - cmd_ready=0 while rst_n=1; cmd_ready=1 in the first cycle after reset deasserts.
- Command accepted on edge N:
  - Cycle N+1 is ISSUE, with the strobe high.
  - Cycle N+2 is the first WAIT cycle. A read completes here, since the bank sets done on the edge after the strobe. A write completes at N+3.
- Minimum accept-to-rsp_valid latency: 3 cycles for a read, 4 for a write.
- Timeout response: rsp_valid rises timeout_cycles+2 cycles after acceptance.
- Throughput: at most one outstanding access. The next command can be accepted on the edge after the response handshake.
- Reset mid-operation, in any state, on the reset edge:
  - All outputs and state take their reset values.
  - Any pending strobe, access or response is dropped.
  - No response is ever produced for the aborted command.
- rsp_ready held high in RESP: the handshake completes in the first RESP cycle.

## Structure
- Shared package decryption_pkg holds:
  - The FSM state encoding.
  - Bank register address constants: SELECT_ADDR=0x00, CAESAR_KEY_ADDR=0x10, SCYTALE_KEY_ADDR=0x12, ZIGZAG_KEY_ADDR=0x14.
  - Default widths (8/16).
- One natural sub-module: decryption_timeout_cnt, a saturating counter with clear and enable inputs and an expired output. Everything else stays in the top module.

## Test plan
- Write 0x0003 to 0x12 with a bank model that asserts done one cycle late: write=1 for exactly one cycle with addr=0x12 and wdata=0x0003; response rsp_error=0, rsp_timeout=0, rsp_rdata=0, latency 4.
- Read 0x10 after writing 0x00AB: read strobe for one cycle; response rsp_rdata=0x00AB, rsp_error=0, latency 3.
- Read 0x55 with the bank asserting error and done: rsp_error=1, rsp_timeout=0, rsp_rdata=0.
- Bank never asserts done, timeout_cycles=16: rsp_valid 18 cycles after acceptance, with rsp_error=1 and rsp_timeout=1; cmd_ready stays 0 throughout.
- rsp_ready held low for 5 cycles, with cmd_valid high and a stray done injected: rsp_* stable, cmd_ready=0, no new strobe; command accepted only after the response handshake.
- rst_n=1 pulsed during WAIT: next cycle all outputs 0, state IDLE; no response is ever produced for the aborted command.
